// File: rtl/regfile_scoreboard.sv
// Register file with async read ports and a per-register in-flight write scoreboard.
// Define SB_WB_BYPASS_EN to enable same-cycle WB->ID forwarding.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 3,
  parameter int CNT_W    = 2,
  parameter int HARD_REG = 30,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  input  logic                  iss_valid,
  input  logic                  iss_we,
  input  logic [AW-1:0]         iss_dst,
  input  logic                  wb_en,
  input  logic [AW-1:0]         wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  stall,
  output logic [NREGS-1:0]      busy_vec,
  output logic                  sb_err
);

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);
  localparam logic [AW-1:0]    HR   = AW'(HARD_REG);

  logic [DATA_W-1:0] regs [NREGS];
  logic [CNT_W-1:0]  cnt  [NREGS];
  logic [NRD-1:0]    hazard;
  logic [NRD-1:0]    byp;
  logic [NREGS-1:0]  inc_v;
  logic [NREGS-1:0]  dec_v;
  logic              sat;
  logic              accept;

  function automatic logic hw(input logic [AW-1:0] a);
    return (a == '0) || (a == HR);
  endfunction

  always_comb begin
    hazard  = '0;
    byp     = '0;
    rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      if (!hw(rd_addr[i*AW +: AW])) begin
`ifdef SB_WB_BYPASS_EN
        byp[i] = wb_en && (wb_addr == rd_addr[i*AW +: AW])
              && (cnt[rd_addr[i*AW +: AW]] == CONE);
`else
        byp[i] = 1'b0;
`endif
        rd_data[i*DATA_W +: DATA_W] = byp[i] ? wb_data
                                    : regs[rd_addr[i*AW +: AW]];
        hazard[i] = rd_en[i] && !byp[i]
                 && (cnt[rd_addr[i*AW +: AW]] != '0);
      end
    end
  end

  // Saturation is judged on the pre-retire count, even if WB hits the same reg.
  always_comb begin
    sat    = iss_we && !hw(iss_dst) && (cnt[iss_dst] == CMAX);
    stall  = iss_valid && ((|hazard) || sat);
    accept = iss_valid && !stall;
  end

  always_comb begin
    inc_v    = '0;
    dec_v    = '0;
    busy_vec = '0;
    for (int r = 0; r < NREGS; r++) begin
      inc_v[r] = accept && iss_we && !hw(iss_dst)
              && (iss_dst == AW'(r));
      dec_v[r] = wb_en && (wb_addr == AW'(r)) && (cnt[r] != '0);
      busy_vec[r] = (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      if (wb_en && !hw(wb_addr)) begin
        regs[wb_addr] <= wb_data;
        if (cnt[wb_addr] == '0)
          sb_err <= 1'b1;
      end
      for (int r = 0; r < NREGS; r++) begin
        if (inc_v[r] && !dec_v[r])
          cnt[r] <= cnt[r] + CONE;
        else if (dec_v[r] && !inc_v[r])
          cnt[r] <= cnt[r] - CONE;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: directed scenarios then random traffic,
// expected outputs from an array/int reference model queued and checked by a monitor.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  rd_en;
  logic [14:0] rd_addr;
  logic [95:0] rd_data;
  logic        iss_valid;
  logic        iss_we;
  logic [4:0]  iss_dst;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall;
  logic [31:0] busy_vec;
  logic        sb_err;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .iss_valid(iss_valid), .iss_we(iss_we),
    .iss_dst(iss_dst), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .stall(stall), .busy_vec(busy_vec),
    .sb_err(sb_err)
  );

  typedef struct {
    logic [95:0] rd;
    logic        stl;
    logic [31:0] busy;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mmem [32];
  int          mcnt [32];
  bit          merr;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic bit hwr(input logic [4:0] a);
    return (a == 5'd0) || (a == 5'd30);
  endfunction

  function automatic void chk(input string nm,
                              input logic [95:0] act,
                              input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rd_data", rd_data, e.rd);
      chk("stall", 96'(stall), 96'(e.stl));
      chk("busy_vec", 96'(busy_vec), 96'(e.busy));
      chk("sb_err", 96'(sb_err), 96'(e.err));
    end
  end

  // One clock: drive, predict outputs, advance the model at the edge.
  task automatic cyc(input bit r, input logic [2:0] en,
                     input logic [4:0] a0, input logic [4:0] a1,
                     input logic [4:0] a2, input bit iv, input bit we,
                     input logic [4:0] dst, input bit wb,
                     input logic [4:0] wa, input logic [31:0] wd,
                     input bit do_chk = 1'b1);
    exp_t        e;
    logic [4:0]  a [3];
    bit          haz;
    bit          bp;
    bit          acc;
    rst_n = !r; rd_en = en; rd_addr = {a2, a1, a0};
    iss_valid = iv; iss_we = we; iss_dst = dst;
    wb_en = wb; wb_addr = wa; wb_data = wd;
    a[0] = a0; a[1] = a1; a[2] = a2;
    haz = 1'b0;
    e.rd = '0;
    for (int i = 0; i < 3; i++) begin
      if (!hwr(a[i])) begin
`ifdef SB_WB_BYPASS_EN
        bp = wb && (wa == a[i]) && (mcnt[a[i]] == 1);
`else
        bp = 1'b0;
`endif
        e.rd[i*32 +: 32] = bp ? wd : mmem[a[i]];
        if (en[i] && mcnt[a[i]] != 0 && !bp) haz = 1'b1;
      end
    end
    e.stl = iv && (haz || (we && !hwr(dst) && mcnt[dst] == 3));
    acc = iv && !e.stl;
    for (int k = 0; k < 32; k++) e.busy[k] = (mcnt[k] != 0);
    e.err = merr;
    if (do_chk) q.push_back(e);
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 32; k++) begin
        mmem[k] = '0;
        mcnt[k] = 0;
      end
      merr = 1'b0;
    end else begin
      if (wb && !hwr(wa)) begin
        mmem[wa] = wd;
        if (mcnt[wa] > 0) mcnt[wa]--;
        else merr = 1'b1;
      end
      if (acc && we && !hwr(dst)) mcnt[dst]++;
    end
    #1;
  endtask

  task automatic rd1(input logic [4:0] a, input bit iv = 1'b0);
    cyc(0, 3'b001, a, 5'd0, 5'd0, iv, 0, 5'd0, 0, 5'd0, 0);
  endtask

  task automatic iss(input logic [4:0] d, input bit wb = 1'b0,
                     input logic [4:0] wa = 5'd0,
                     input logic [31:0] wd = 0);
    cyc(0, 3'b000, 5'd0, 5'd0, 5'd0, 1, 1, d, wb, wa, wd);
  endtask

  task automatic ret(input logic [4:0] wa, input logic [31:0] wd);
    cyc(0, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 1, wa, wd);
  endtask

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    rst_n = 1'b0; rd_en = '0; rd_addr = '0; iss_valid = 1'b0;
    iss_we = 1'b0; iss_dst = '0; wb_en = 1'b0; wb_addr = '0;
    wb_data = '0; merr = 1'b0;
    for (int k = 0; k < 32; k++) begin
      mmem[k] = '0;
      mcnt[k] = 0;
    end
    #1;
    // reset, then read R1..R3
    cyc(1, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 1'b0);
    cyc(1, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0);
    cyc(0, 3'b111, 5'd1, 5'd2, 5'd3, 0, 0, 5'd0, 0, 5'd0, 0);
    // RAW on R5
    iss(5'd5);
    rd1(5'd5, 1);
    rd1(5'd5, 1);
    cyc(0, 3'b001, 5'd5, 5'd0, 5'd0, 1, 0, 5'd0, 1, 5'd5, 32'h1234);
    rd1(5'd5, 1);
    rd1(5'd5, 1);
    // WAW on R7
    iss(5'd7);
    iss(5'd7);
    ret(5'd7, 32'hA);
    rd1(5'd7);
    ret(5'd7, 32'hB);
    rd1(5'd7);
    // saturation on R9
    iss(5'd9); iss(5'd9); iss(5'd9);
    iss(5'd9);
    iss(5'd9, 1, 5'd9, 32'h9);
    iss(5'd9);
    ret(5'd9, 32'h19);
    iss(5'd9, 1, 5'd9, 32'h29);
    rd1(5'd9);
    ret(5'd9, 32'h39); ret(5'd9, 32'h49); ret(5'd9, 32'h59);
    rd1(5'd9);
    // hardwired registers
    iss(5'd0); iss(5'd30);
    ret(5'd0, 32'hFFFF); ret(5'd30, 32'hFFFF);
    cyc(0, 3'b011, 5'd0, 5'd30, 5'd0, 1, 0, 5'd0, 0, 5'd0, 0);
    // spurious retire, then reset mid-flight
    ret(5'd12, 32'h55);
    rd1(5'd12);
    iss(5'd4); iss(5'd4);
    rd1(5'd4, 1);
    cyc(1, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0);
    rd1(5'd4, 1);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int          bq[$];
      bit          wb;
      logic [4:0]  wa;
      wb = 1'b0;
      wa = pick();
      for (int k = 0; k < 32; k++) if (mcnt[k] != 0) bq.push_back(k);
      if (bq.size() != 0 && $urandom_range(0, 9) < 4) begin
        wb = 1'b1;
        wa = 5'(bq[$urandom_range(0, bq.size() - 1)]);
      end else if ($urandom_range(0, 99) < 3) begin
        wb = 1'b1;
      end
      cyc($urandom_range(0, 299) == 0, 3'($urandom_range(0, 7)),
          pick(), pick(), pick(), $urandom_range(0, 9) < 7,
          $urandom_range(0, 9) < 7, pick(), wb, wa, $urandom);
    end
    rd1(5'd1);
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
